// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width and the feeder state encoding.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ISSUE     = 2'b01,
      WAIT_ACK  = 2'b10,
      WAIT_DONE = 2'b11
   } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty, entry count and sticky overflow.
// rd_data always shows the head entry; rd_en advances past it.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_acc  = wr_en & ~full;
   assign rd_acc  = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc) begin
         count_nxt = count + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // Flags are registered from the next count so they line up with count itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         empty <= (count_nxt == '0);
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered host bytes to the UART transmitter, one word in flight at a time.
//   state     | meaning
//   IDLE      | wait for a queued word and an idle transmitter, then pop it
//   ISSUE     | tx_data_valid high for this single cycle
//   WAIT_ACK  | wait for the transmitter to raise busy
//   WAIT_DONE | wait for busy to fall, ending the frame
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   input  logic                    tx_busy,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_data_valid
);

   feeder_state_e         state;
   feeder_state_e         state_nxt;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)      tx_data <= '0;
      else if (pop) tx_data <= head;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:     state_nxt = WAIT_ACK;
         WAIT_ACK:  if (tx_busy)  state_nxt = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign tx_data_valid = (state == ISSUE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: busy-model transmitter, scoreboard of issued words, table-driven burst.
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          full;
   logic          empty;
   logic [3:0]    count;
   logic          overflow;
   logic          tx_busy = 1'b0;
   logic [DW-1:0] tx_data;
   logic          tx_data_valid;

   uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .overflow      (overflow),
      .tx_busy       (tx_busy),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];
   int            cyc = 0;
   int            pulses = 0;
   int            valid_cyc = 0;
   int            drop_cyc = 0;
   int            busy_left = 0;
   bit            busy_model = 1'b1;
   bit            force_busy = 1'b0;
   bit            seen_valid = 1'b0;
   bit            prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transmitter model: busy rises the cycle after it samples data_valid, holds for 11 cycles.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy_model && seen_valid) busy_left = 11;
      tx_busy = force_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (prev_busy && !tx_busy) drop_cyc = cyc;
      prev_busy = tx_busy;
      if (tx_data_valid) begin
         pulses++;
         valid_cyc = cyc;
         check("valid_single_cycle", {31'd0, seen_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse actual tx_data=%0h required=no pulse", tx_data);
         end else begin
            check("sb_tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
         end
      end
      seen_valid = tx_data_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [DW-1:0] d);
      int n = 0;
      while (full && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("write_not_full", {31'd0, full}, 32'd0);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget, input string name);
      int n = 0;
      while (pulses < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, pulses, target);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || tx_busy || dut.state != IDLE) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (exp_q.size() == 0 && !tx_busy && dut.state == IDLE)}, 32'd1);
   endtask

   typedef struct {
      logic          wr_en;
      logic [DW-1:0] data;
      logic          accept;
      logic [3:0]    exp_count;
      logic          exp_full;
      logic          exp_ovf;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int p0;
      int wcyc;

      for (int i = 0; i < 10; i++) begin
         vecs[i].wr_en     = (i < 9);
         vecs[i].data      = DW'(i + 1);
         vecs[i].accept    = (i < 8);
         vecs[i].exp_count = (i < 8) ? 4'(i + 1) : 4'd8;
         vecs[i].exp_full  = (i >= 7);
         vecs[i].exp_ovf   = (i >= 8);
      end

      repeat (3) @(negedge clk);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_valid", {31'd0, tx_data_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single word, write-to-valid latency
      p0 = pulses;
      wcyc = cyc;
      do_write(8'hA5);
      wait_pulses(p0 + 1, 20, "a5_pulse");
      check("a5_latency", valid_cyc - wcyc, 2);
      check("a5_count_after_pop", {28'd0, count}, 32'd0);
      wait_drain("a5_drain");
      check("a5_single_pulse", pulses, p0 + 1);

      // Burst into a blocked transmitter, ninth write overflows
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         wr_en   = vecs[i].wr_en;
         wr_data = vecs[i].data;
         if (vecs[i].accept) exp_q.push_back(vecs[i].data);
         @(negedge clk);
         check($sformatf("burst%0d_count", i), {28'd0, count}, {28'd0, vecs[i].exp_count});
         check($sformatf("burst%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
         check($sformatf("burst%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      end
      wr_en = 1'b0;
      check("burst_no_pulse_while_busy", pulses, p0);
      force_busy = 1'b0;
      wait_pulses(p0 + 8, 400, "burst_8_issued");
      wait_drain("burst_drain");
      check("burst_9_dropped", pulses, p0 + 8);
      check("burst_empty", {31'd0, empty}, 32'd1);

      // Held busy with three words queued
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      p0 = pulses;
      do_write(8'h31);
      do_write(8'h32);
      do_write(8'h33);
      repeat (5) @(negedge clk);
      check("hold_no_pulse", pulses, p0);
      check("hold_count", {28'd0, count}, 32'd3);
      force_busy = 1'b0;
      wait_pulses(p0 + 1, 20, "hold_first_pulse");
      check("hold_issue_after_drop", valid_cyc - drop_cyc, 1);
      wait_drain("hold_drain");

      // Simultaneous write and pop at count=3, then stream 20 words through the wrap
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      do_write(8'h40);
      do_write(8'h41);
      do_write(8'h42);
      force_busy = 1'b0;
      @(negedge clk);
      check("simul_pre_idle", {31'd0, (tx_busy == 1'b0 && dut.state == IDLE)}, 32'd1);
      do_write(8'h43);
      check("simul_count_3", {28'd0, count}, 32'd3);
      for (int i = 4; i < 20; i++) do_write(DW'(8'h40 + i));
      wait_drain("wrap_drain");

      // Reset in WAIT_DONE with four words queued
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) do_write(DW'(8'h70 + i));
      p0 = pulses;
      force_busy = 1'b0;
      wait_pulses(p0 + 1, 20, "rst_mid_first_pulse");
      repeat (4) @(negedge clk);
      check("rst_mid_state", dut.state, WAIT_DONE);
      check("rst_mid_count_pre", {28'd0, count}, 32'd4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      check("rst_mid_count", {28'd0, count}, 32'd0);
      check("rst_mid_empty", {31'd0, empty}, 32'd1);
      check("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
      repeat (30) @(negedge clk);
      check("rst_mid_no_more_pulses", pulses, p0 + 1);

      // Transmitter that never acknowledges
      busy_model = 1'b0;
      p0 = pulses;
      do_write(8'h66);
      repeat (20) @(negedge clk);
      check("noack_one_pulse", pulses, p0 + 1);
      check("noack_state", dut.state, WAIT_ACK);
      check("noack_tx_data", {24'd0, tx_data}, 32'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Buffers parallel bytes from the system side and hands them one at a time to the UART transmitter. It sits directly upstream of the UART TX datapath and FSM. It drives the transmitter's `data_valid`/`P_DATA` inputs and paces itself on the transmitter's `busy` output. A small synchronous FIFO absorbs bursts, so the host never has to poll `busy`.

## Interface
- `DATA_WIDTH`, 8: width of each byte/word sent to the transmitter.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock domain for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe; `wr_data` is written when `wr_en=1` and `full=0`.
- `wr_data`  in  DATA_WIDTH  host data.
- `full`  out  1  FIFO full; registered.
- `empty`  out  1  FIFO empty; registered.
- `count`  out  $clog2(DEPTH)+1  number of entries stored.
- `overflow`  out  1  sticky; set by any write while full; cleared only by `rst`.
- `tx_busy`  in  1  `busy` from the UART TX.
- `tx_data`  out  DATA_WIDTH  to transmitter `P_DATA`; registered; holds its value until the next pop.
- `tx_data_valid`  out  1  to transmitter `data_valid`; exactly one-cycle pulse per word.

## Operation
- FIFO write: when `wr_en & !full`, store the word at the write pointer and increment the pointer.
- Write while full: the word is dropped and `overflow` is set. This applies even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. `count` is incremented on a write, decremented on a pop, and unchanged on a simultaneous write and pop.
- Feeder FSM has four states:
  - IDLE: if `!empty & !tx_busy`, pop the FIFO head into `tx_data` and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `tx_data_valid=1` for this cycle only. Unconditionally go to WAIT_ACK.
  - WAIT_ACK: if `tx_busy=1`, go to WAIT_DONE. Otherwise stay in WAIT_ACK; `tx_data_valid` is not re-asserted.
  - WAIT_DONE: if `tx_busy=0`, go to IDLE.
- Exactly one word is in flight. There is no back-to-back issue during the transmitter's stop bit; each frame is followed by at least one idle cycle.
- `tx_data_valid` is decoded from state == ISSUE, so it is glitch-free and registered-state based.
- Reset values: `full=0`, `empty=1`, `count=0`, `overflow=0`, `tx_data=0`, `tx_data_valid=0`, FSM in IDLE, pointers at 0.
- Reset mid-frame: the FIFO contents are discarded and the FSM returns to IDLE. The transmitter's frame in progress is not the feeder's concern. After reset, the feeder will not issue until `tx_busy=0`.

## Timing
- Write at edge N: `count` and `empty` update after edge N and are visible in cycle N+1.
- Issue path, assuming the transmitter is idle:
  - IDLE sees `!empty` in cycle N+1.
  - Pop occurs at edge N+1.
  - ISSUE, with `tx_data_valid=1` and `tx_data` valid, in cycle N+2.
  - The transmitter samples at edge N+2 and `tx_busy` rises in N+3.
  - WAIT_DONE from N+4.
- Write-to-`tx_data_valid` latency: 2 cycles.
- `tx_data` changes only at a pop edge. It is stable throughout the ISSUE cycle and the whole frame.
- After `tx_busy` falls in cycle M, the FSM is in IDLE at M+1. The next `tx_data_valid` occurs no earlier than M+2.
- Pop decrements `count` at the same edge that loads `tx_data`.

## Structure
- Shared package `uart_pkg`:
  - `feeder_state_e`, 2-bit enum: IDLE=2'b00, ISSUE=2'b01, WAIT_ACK=2'b10, WAIT_DONE=2'b11.
  - Default `DATA_WIDTH` constant, shared with the TX datapath.
- Sub-module `sync_fifo`:
  - Parameterised by `DATA_WIDTH` and `DEPTH`.
  - Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`, `overflow`.
  - `rd_data` is the head combinationally; `rd_en` advances it.
- Top level: the feeder FSM and the `tx_data` register, plus the `sync_fifo` instance.

## Test plan
- Reset, then write 0xA5 with `tx_busy` held 0 and a busy model that rises one cycle after `tx_data_valid` and stays high 11 cycles:
  - `tx_data_valid` is a single-cycle pulse 2 cycles after the write, with `tx_data=0xA5`.
  - `count` returns to 0.
- Burst-write 0x01..0x08 on consecutive cycles:
  - `full=1` after the 8th write; a 9th write, 0x09, sets `overflow`.
  - 0x01..0x08 are issued in order, one per busy frame.
  - 0x09 is never seen.
- Hold `tx_busy=1` externally with 3 words queued:
  - No `tx_data_valid` while busy.
  - First issue occurs 1 cycle after `tx_busy` drops.
- Write on the same cycle as a pop with `count=3`:
  - `count` stays 3.
  - Data order is preserved across pointer wrap over 20 words.
- Assert `rst` during WAIT_DONE with 4 words queued:
  - Next cycle: `count=0`, `empty=1`, `tx_data=0`, `overflow=0`.
  - No further `tx_data_valid` pulses.
- Busy model that never raises `tx_busy` after the pulse:
  - FSM stays in WAIT_ACK.
  - `tx_data_valid` is asserted exactly once.
